// File: rtl/cluster_frame_tx_pkg.sv
// Shared constants and FSM encoding for the cluster transmit path.
package cluster_pkg;

  localparam int NCLUST = 8;      // clusters per frame
  localparam int ADRB   = 11;     // address width
  localparam int CNTB   = 3;      // cluster-size count width
  localparam int MAX_ADR = 1536;  // first invalid address (empty slot marker)
  localparam logic [10:0] NULL_ADR = 11'h7FF;

  // Output word layout: [15] SOF, [14] EOF, [13:11] cnt, [10:0] adr.
  localparam int WORDW   = 16;
  localparam int SOF_BIT = 15;
  localparam int EOF_BIT = 14;
  localparam int CNT_LSB = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/cluster_frame_tx_select8.sv
// Combinational lowest-set-bit picker: index of the lowest set mask bit,
// whether any bit is set, and the mask with that bit cleared.
module cluster_select8 #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic [N-1:0]  rest
);

  // Scan high to low so the last hit, the lowest set bit, wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
    any  = |mask;
    rest = mask & (mask - N'(1));
  end

endmodule

// File: rtl/cluster_frame_tx.sv
// Cluster frame transmitter: 2-entry frame FIFO in front of a serialiser
// that emits one word per valid cluster, flagged with SOF/EOF.
module cluster_frame_tx #(
  parameter int NCLUST  = cluster_pkg::NCLUST,
  parameter int ADRB    = cluster_pkg::ADRB,
  parameter int CNTB    = cluster_pkg::CNTB,
  parameter int MAX_ADR = cluster_pkg::MAX_ADR,
  parameter logic [ADRB-1:0] NULL_ADR = cluster_pkg::NULL_ADR
) (
  input  logic                     clock4x,
  input  logic                     global_reset,
  input  logic                     frame_valid,
  input  logic [NCLUST*ADRB-1:0]   adr_in,
  input  logic [NCLUST*CNTB-1:0]   cnt_in,
  output logic [15:0]              tx_data,
  output logic                     tx_valid,
  output logic [7:0]               ovf_cnt,
  output logic                     busy
);

  import cluster_pkg::*;

  localparam int IDXW = $clog2(NCLUST);

  // Frame FIFO storage and bookkeeping.
  logic [NCLUST*ADRB-1:0] fifo_adr_q  [2];
  logic [NCLUST*CNTB-1:0] fifo_cnt_q  [2];
  logic [NCLUST-1:0]      fifo_mask_q [2];
  logic                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic [7:0]             ovf_q, ovf_d;
  logic                   busy_q, busy_d;

  // Serialiser working registers.
  state_e                 state_q, state_d;
  logic [NCLUST*ADRB-1:0] adr_q, adr_d;
  logic [NCLUST*CNTB-1:0] cnt_q, cnt_d;
  logic [NCLUST-1:0]      mask_q, mask_d;
  logic                   first_q, first_d;
  logic [WORDW-1:0]       tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;

  logic [NCLUST-1:0]      in_mask;
  logic                   push, pop, drop, eof;
  logic [IDXW-1:0]        sel_idx;
  logic                   sel_any;
  logic [NCLUST-1:0]      sel_rest;

  cluster_select8 #(.N(NCLUST), .IW(IDXW)) u_select (
    .mask (mask_q),
    .idx  (sel_idx),
    .any  (sel_any),
    .rest (sel_rest)
  );

  // Valid mask of the incoming frame: a slot is live when its address is in range.
  always_comb begin
    for (int i = 0; i < NCLUST; i++) begin
      in_mask[i] = ({1'b0, adr_in[i*ADRB +: ADRB]} < (ADRB + 1)'(MAX_ADR));
    end
  end

  // Serialiser FSM: pop a frame, then emit one word per set mask bit.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    state_d    = state_q;
    adr_d      = adr_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    first_d    = first_q;
    tx_data_d  = '0;
    tx_valid_d = 1'b0;
    pop        = 1'b0;
    eof        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_valid_d         = 1'b1;
        tx_data_d[SOF_BIT] = first_q;
        first_d            = 1'b0;
        if (!sel_any) begin
          // Empty frame still produces one word carrying NULL_ADR.
          tx_data_d[ADRB-1:0] = NULL_ADR;
          eof                 = 1'b1;
        end else begin
          tx_data_d[CNT_LSB +: CNTB] = cnt_q[sel_idx*CNTB +: CNTB];
          tx_data_d[ADRB-1:0]        = adr_q[sel_idx*ADRB +: ADRB];
          mask_d                     = sel_rest;
          eof                        = (sel_rest == '0);
        end
        tx_data_d[EOF_BIT] = eof;
        // Chain straight into the next buffered frame so frames leave gap-free.
        if (eof) begin
          if (count_q != 2'd0) pop = 1'b1;
          else                 state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      adr_d   = fifo_adr_q[rd_ptr_q];
      cnt_d   = fifo_cnt_q[rd_ptr_q];
      mask_d  = fifo_mask_q[rd_ptr_q];
      first_d = 1'b1;
    end
  end

  // FIFO pointers, overflow counting and the busy flag.
  always_comb begin
    // A full FIFO still accepts a frame on an edge where one is popped.
    push     = frame_valid && ((count_q != 2'd2) || pop);
    drop     = frame_valid && (count_q == 2'd2) && !pop;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    ovf_d    = ovf_q;
    if (drop && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
    busy_d   = (count_d != 2'd0) || (state_d == ST_SEND);
  end

  // FIFO payload storage.
  // NOTE: the payload array is not reset; the pointers and count decide what is valid.
  always_ff @(posedge clock4x) begin
    if (push) begin
      fifo_adr_q[wr_ptr_q]  <= adr_in;
      fifo_cnt_q[wr_ptr_q]  <= cnt_in;
      fifo_mask_q[wr_ptr_q] <= in_mask;
    end
  end

  // Control and output registers, cleared asynchronously.
  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      ovf_q      <= 8'd0;
      busy_q     <= 1'b0;
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      first_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      state_q    <= state_d;
      adr_q      <= adr_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      first_q    <= first_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign ovf_cnt  = ovf_q;
  assign busy     = busy_q;

endmodule
